muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded Operand1/Operand2 the ALU sees and produces a 32-bit result that the EX result mux selects in place of AluOut.
- Stalls the pipeline through the hazard unit while iterating.
- Iterative radix-2: 32 shift-add steps for multiply, 32 restoring steps for divide, then a sign-fixup cycle.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_iter.sv | 58 +++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation encodings
// and small decode helpers used by the unit and its iteration datapath.
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    // MulDivOp encodings, matching the M-extension funct3 field.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    // Divide-class ops all have bit 2 set.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // rs1 is interpreted as signed for these ops.
    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as signed for these ops (MULHSU treats it unsigned).
    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iteration datapath: 64-bit accumulator, 5-bit step counter and
// the per-cycle shift-add (multiply) or restoring-subtract (divide) step.
// Operands are unsigned magnitudes held stable by the parent for the whole
// operation. Multiply walks the multiplier MSB-first; divide produces one
// quotient bit per step with the remainder in acc[63:32] and the quotient
// in acc[31:0].
module muldiv_iter
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [63:0] init_val,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc,
    output logic [4:0]  cnt
);

    logic [4:0]  bit_idx;
    logic [63:0] mul_next;
    logic [32:0] trial;
    logic [31:0] rem_sub;
    logic [63:0] div_next;

    // Next accumulator value for one multiply or one divide step.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no path can infer a latch.
        div_next = '0;
        bit_idx  = 5'd31 - cnt;
        mul_next = {acc[62:0], 1'b0} + {32'd0, opa & {XLEN{opb[bit_idx]}}};
        trial    = {acc[63:32], opa[bit_idx]};
        rem_sub  = trial[31:0] - opb;
        if (trial >= {1'b0, opb}) begin
            div_next = {rem_sub, acc[30:0], 1'b1};
        end else begin
            div_next = {trial[31:0], acc[30:0], 1'b0};
        end
    end

    // Accumulator and counter: load on start, advance one step per RUN cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them sample pre-edge values.
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (init) begin
            acc <= init_val;
            cnt <= '0;
        end else if (step) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit sitting beside the ALU in EX.
// FSM IDLE -> RUN (32 steps) -> FIX (sign fixup, result register, Done).
// Divide by zero and signed overflow skip RUN and finish in two cycles.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33
// signed product and also skip RUN; divides are unaffected.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [2:0]       MulDivOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MulDivOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e      state;
    muldiv_op_e  op_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        neg_q;

    muldiv_op_e  op_in;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_in;
    logic        div_zero;
    logic        div_ovf;
    logic        fast_mul;
    logic [63:0] fast_prod;
    logic [63:0] init_val;
    logic        skip_run;
    logic        start_go;

    logic [63:0] acc;
    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_result;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a;
    logic signed [32:0] fast_b;

    // Single-cycle product of the sign-extended operands.
    always_comb begin
        fast_a    = {sign_a, Operand1};
        fast_b    = {sign_b, Operand2};
        fast_mul  = !op_is_div(op_in);
        fast_prod = 64'(fast_a) * 64'(fast_b);
    end
`else
    assign fast_mul  = 1'b0;
    assign fast_prod = '0;
`endif

    // Operand conditioning, result sign and special-case detection.
    always_comb begin
        op_in    = muldiv_op_e'(MulDivOp);
        sign_a   = op_a_signed(op_in) & Operand1[31];
        sign_b   = op_b_signed(op_in) & Operand2[31];
        mag_a    = sign_a ? (32'd0 - Operand1) : Operand1;
        mag_b    = sign_b ? (32'd0 - Operand2) : Operand2;
        case (op_in)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV: neg_in = sign_a ^ sign_b;
            OP_REM:                             neg_in = sign_a;
            default:                            neg_in = 1'b0;
        endcase
        div_zero = op_is_div(op_in) && (Operand2 == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (Operand1 == 32'h8000_0000) && (Operand2 == 32'hFFFF_FFFF);
        // Special cases and the fast product preload their final value.
        init_val = '0;
        if (div_zero) begin
            init_val = {Operand1, 32'hFFFF_FFFF};
        end else if (div_ovf) begin
            init_val = {32'd0, 32'h8000_0000};
        end else if (fast_mul) begin
            init_val = fast_prod;
        end
        skip_run = div_zero || div_ovf || fast_mul;
        start_go = (state == S_IDLE) && Start && !Done && !Flush;
    end

    muldiv_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .init     (start_go),
        .init_val (init_val),
        .step     (state == S_RUN),
        .is_div   (op_is_div(op_q)),
        .opa      (opa_q),
        .opb      (opb_q),
        .acc      (acc),
        .cnt      (cnt)
    );

    // Sign fixup and result selection for the FIX cycle.
    always_comb begin
        prod = neg_q ? (64'd0 - acc) : acc;
        quo  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        rem  = neg_q ? (32'd0 - acc[63:32]) : acc[63:32];
        case (op_q)
            OP_MUL:                      fix_result = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[63:32];
            OP_DIV, OP_DIVU:             fix_result = quo;
            default:                     fix_result = rem;
        endcase
    end

    // Control FSM with registered Busy/Done/MulDivOut; Flush aborts silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_MUL;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            MulDivOut <= '0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_go) begin
                            op_q  <= op_in;
                            opa_q <= mag_a;
                            opb_q <= mag_b;
                            neg_q <= skip_run ? 1'b0 : neg_in;
                            Busy  <= 1'b1;
                            state <= skip_run ? S_FIX : S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (cnt == 5'd31) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        MulDivOut <= fix_result;
                        Done      <= 1'b1;
                        Busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized
// operations against an arithmetic reference model, flush, held Start and
// mid-operation reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic        Flush;
    logic [2:0]  MulDivOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        Busy;
    logic        Done;
    logic [31:0] MulDivOut;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [12] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{3'd5, 32'd100,        32'd7,         32'd14},
        '{3'd7, 32'd100,        32'd7,         32'd2},
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'd5,          32'd0,         32'd5},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
    };

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Flush     (Flush),
        .MulDivOp  (MulDivOp),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Busy      (Busy),
        .Done      (Done),
        .MulDivOut (MulDivOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'd0, a};
        longint ub = {32'd0, b};
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the Start cycle to the Done cycle, both inclusive.
    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 2;
`endif
        return 34;
    endfunction

    // Issue one op, wait for Done, check result, latency and pulse width.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int cyc;
        int lat;
        int exp_lat;
        exp_lat = exp_latency(op, a, b);
        @(negedge clk);
        MulDivOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        MulDivOp = 3'($urandom);
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b want 1", name, Busy);
        end
        cyc = 0;
        while (Done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (Done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: no Done within 100 cycles", name);
            return;
        end
        lat = cyc + 1;
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (MulDivOut !== exp) begin
            n_fail++;
            $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", name, op, a, b, MulDivOut, exp);
        end
        last_exp = exp;
        @(posedge clk);
        #1;
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || MulDivOut !== exp) begin
            n_fail++;
            $display("FAIL %s after_done: Done=%b Busy=%b out=%h want 0 0 %h", name, Done, Busy, MulDivOut, exp);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        Start    = 1'b0;
        Flush    = 1'b0;
        MulDivOp = '0;
        Operand1 = '0;
        Operand2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || MulDivOut !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: Busy=%b Done=%b out=%h want 0 0 0", Busy, Done, MulDivOut);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("directed%0d", i));
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, ref_result(op, a, b), $sformatf("random%0d", i));
        end
    endtask

    task automatic test_flush();
        int dones;
        // Start and Flush together: nothing starts.
        @(negedge clk);
        MulDivOp = 3'd4;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        Start    = 1'b1;
        Flush    = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Flush = 1'b0;
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_with_start: Busy=%b want 0", Busy);
        end
        // Flush in cycle 10 of a DIV.
        @(negedge clk);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mid_div: Busy=%b Done=%b want 0 0", Busy, Done);
        end
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || MulDivOut !== last_exp) begin
            n_fail++;
            $display("FAIL flush_no_done: dones=%0d out=%h want 0 %h", dones, MulDivOut, last_exp);
        end
        run_op(3'd4, 32'd1000, 32'd3, 32'd333, "after_flush");
    endtask

    task automatic test_start_held();
        int cyc;
        int dones;
        @(negedge clk);
        MulDivOp = 3'd5;
        Operand1 = 32'd100;
        Operand2 = 32'd7;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        cyc   = 0;
        dones = 0;
        while (Done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (Done === 1'b1) dones++;
        n_checks++;
        if (MulDivOut !== 32'd14 || dones != 1) begin
            n_fail++;
            $display("FAIL start_held_result: dones=%0d out=%h want 1 %h", dones, MulDivOut, 32'd14);
        end
        // Start still high across the Done edge: must not retrigger.
        @(posedge clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_held_no_restart: Busy=%b Done=%b want 0 0", Busy, Done);
        end
        @(negedge clk);
        Start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL start_held_pulses: got %0d want 1", dones);
        end
        last_exp = 32'd14;
    endtask

    task automatic test_rst_mid();
        int dones;
        @(negedge clk);
        MulDivOp = 3'd0;
        Operand1 = 32'd12345;
        Operand2 = 32'd678;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || MulDivOut !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_run: Busy=%b Done=%b out=%h want 0 0 0", Busy, Done, MulDivOut);
        end
        last_exp = 32'd0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %0d pulses want 0", dones);
        end
        run_op(3'd0, 32'd12345, 32'd678, 32'd8369910, "after_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_held();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
